cp_remove: RTL
==============

Name: cp_remove

Overview:
- Receive-path stage directly upstream of the fft block.
- Takes a time-domain LTE sample stream, one slot at a time, and strips the cyclic prefix from each OFDM symbol.
- Emits only the useful N = 2^ldn samples of each symbol, with a block_sync pulse on the first one, ready to drive fft block_sync_i / data_val_i / data_real_i / data_imag_i / ldn_rg_i directly.

Parameters:
DW, 16 (set to `FFT_IN_WIDTH at instantiation), sample component width in bits.

Ports:
clk_sys  input  1  system clock; all logic on its rising edge.
rst_sys_n  input  1  asynchronous active-low reset.
block_sync_i  input  1  marks the first sample (first CP sample of symbol 0) of a slot; qualified by data_val_i.
data_val_i  input  1  input sample valid; gaps allowed.
data_real_i  input  DW  signed real part.
data_imag_i  input  DW  signed imaginary part.
ldn_rg_i  input  4  log2 FFT size, legal 7..11; sampled on a qualified block_sync_i.
cp_mode_i  input  1  0 = normal CP (7 symbols/slot), 1 = extended CP (6 symbols/slot); sampled with ldn_rg_i.
block_sync_o  output  1  high with the first useful sample of each symbol.
data_val_o  output  1  output sample valid.
data_real_o  output  DW  signed real part, passed through unchanged.
data_imag_o  output  DW  signed imaginary part.
ldn_rg_o  output  4  latched ldn for the current slot.
sym_idx_o  output  3  symbol index within slot of the current output sample.
err_o  output  1  sticky: illegal ldn seen; cleared only by reset.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0.
- Slot structure, per symbol, all shifts right by (11 - ldn):
  - Normal CP: CP length 160 for symbol 0, 144 for symbols 1..6.
  - Extended CP: CP length 512 for every symbol, symbols 0..5.
  - Each CP is followed by N useful samples.
- Counters advance only on data_val_i = 1; input gaps produce output gaps with no state change.
- FSM states:
  - IDLE: discard samples. On a qualified block_sync_i, latch ldn and mode, set sym = 0 and cnt = 1 (that sample is CP sample 0), go to CP.
  - CP: discard. When cnt reaches cp_len, set cnt = 0 and go to BODY on the next valid sample.
  - BODY: forward each valid sample. When cnt = N - 1:
    - if sym is the last symbol, go to IDLE;
    - otherwise sym++, cnt = 0, go to CP.
- Output timing:
  - All outputs registered; latency exactly 1 clk_sys from the accepted input sample.
  - block_sync_o = 1 together with data_val_o on the BODY sample with cnt = 0.
  - data_val_o = 0 on any cycle with no forwarded sample; data_*_o hold their last value.
- Resynchronisation: a qualified block_sync_i in any state (CP, BODY, IDLE) aborts the current symbol and restarts the slot at that sample. Ldn and mode are re-latched; no output is produced for that sample.
- Illegal ldn (<7 or >11) on block_sync: set err_o, stay in IDLE, forward nothing until the next legal block_sync.
- A block_sync_i with data_val_i = 0 is ignored.
- ldn_rg_i and cp_mode_i changes between block_syncs are ignored.
- Slot length in input samples:
  - normal: 15360 >> (11 - ldn) (960 at ldn = 7);
  - extended: same as normal.
- Asynchronous reset mid-slot: immediate return to reset values; the next slot needs a new block_sync_i.

Test Plan:
- ldn = 7, normal, continuous valid, one block_sync, 960 samples with ramp data 0..959:
  - 896 output samples;
  - block_sync_o on inputs 10, 147, 284, 421, 558, 695, 832 (each 1 cycle later);
  - first output symbol carries data 10..137;
  - sym_idx_o runs 0..6;
  - IDLE afterwards, extra samples dropped.
- ldn = 11, extended, valid toggling 1/0:
  - 6 × 2048 outputs;
  - first block_sync_o on input sample 512;
  - output gaps mirror input gaps;
  - ldn_rg_o = 11.
- Resync: ldn = 8 normal; second block_sync_i at input sample 300 (inside symbol 1 BODY):
  - current symbol truncated;
  - next block_sync_o on sample 300 + 20, with sym_idx_o = 0.
- block_sync_i with ldn_rg_i = 5:
  - err_o = 1, no data_val_o.
  - Then a legal block_sync with ldn = 9: normal operation resumes, err_o stays 1.
- rst_sys_n pulsed low for 3 cycles during BODY of symbol 3:
  - all outputs 0 asynchronously;
  - no output until the next block_sync_i.
- Back-to-back slots, ldn = 10 normal:
  - block_sync_i on sample 0 and sample 7680;
  - 14 block_sync_o pulses, no missing or duplicated samples across the slot boundary.

Source files
------------

// File: rtl/cp_remove_if.sv
// cp_remove_if: sample-stream bundle around the cyclic-prefix remover
//   master: drives block_sync_i/data_val_i/data_*_i/ldn_rg_i/cp_mode_i, observes the *_o side
//   slave : the remover itself (consumes *_i, produces block_sync_o/data_val_o/data_*_o/ldn_rg_o/sym_idx_o/err_o)
`timescale 1ns/1ps
interface cp_remove_if #(parameter int DW = 16);
  logic                 block_sync_i;
  logic                 data_val_i;
  logic signed [DW-1:0] data_real_i;
  logic signed [DW-1:0] data_imag_i;
  logic [3:0]           ldn_rg_i;
  logic                 cp_mode_i;
  logic                 block_sync_o;
  logic                 data_val_o;
  logic signed [DW-1:0] data_real_o;
  logic signed [DW-1:0] data_imag_o;
  logic [3:0]           ldn_rg_o;
  logic [2:0]           sym_idx_o;
  logic                 err_o;
  modport master (
    output block_sync_i, data_val_i, data_real_i, data_imag_i, ldn_rg_i, cp_mode_i,
    input  block_sync_o, data_val_o, data_real_o, data_imag_o, ldn_rg_o, sym_idx_o, err_o
  );
  modport slave (
    input  block_sync_i, data_val_i, data_real_i, data_imag_i, ldn_rg_i, cp_mode_i,
    output block_sync_o, data_val_o, data_real_o, data_imag_o, ldn_rg_o, sym_idx_o, err_o
  );
endinterface

// File: rtl/cp_remove.sv
// cp_remove: strips the cyclic prefix from each OFDM symbol of an LTE slot ahead of the fft
//   clk_sys   : system clock, rising edge
//   rst_sys_n : asynchronous active-low reset
//   bus       : cp_remove_if slave; *_i is the raw slot stream, *_o the useful samples
//               (block_sync_o on the first useful sample of each symbol, 1-cycle latency)
`timescale 1ns/1ps
module cp_remove #(
  parameter int DW = 16
) (
  input logic         clk_sys,
  input logic         rst_sys_n,
  cp_remove_if.slave  bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CP   = 2'd1;
  localparam logic [1:0] BODY = 2'd2;
  logic [1:0]           state_q, state_d;
  logic [10:0]          cnt_q, cnt_d;
  logic [2:0]           sym_q, sym_d;
  logic [3:0]           ldn_q, ldn_d;
  logic                 ext_q, ext_d;
  logic                 err_q, err_d;
  logic                 val_q, val_d;
  logic                 bs_q, bs_d;
  logic signed [DW-1:0] re_q, re_d;
  logic signed [DW-1:0] im_q, im_d;
  logic [2:0]           symo_q, symo_d;
  logic                 legal, cp_end, body_end, last;
  logic [3:0]           sh;
  logic [10:0]          cp_len, n_m1;
  assign legal    = bus.ldn_rg_i >= 4'd7 && bus.ldn_rg_i <= 4'd11;
  assign sh       = 4'd11 - ldn_q;
  assign cp_len   = ext_q ? (11'd512 >> sh) : ((sym_q == 3'd0 ? 11'd160 : 11'd144) >> sh);
  // wraps to 2047 for ldn = 11, which is exactly N - 1
  assign n_m1     = (11'd1 << ldn_q) - 11'd1;
  assign cp_end   = cnt_q == cp_len - 11'd1;
  assign body_end = cnt_q == n_m1;
  assign last     = sym_q == (ext_q ? 3'd5 : 3'd6);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sym_d   = sym_q;
    ldn_d   = ldn_q;
    ext_d   = ext_q;
    err_d   = err_q;
    val_d   = 1'b0;
    bs_d    = 1'b0;
    re_d    = re_q;
    im_d    = im_q;
    symo_d  = symo_q;
    if (bus.data_val_i) begin
      if (bus.block_sync_i) begin
        // the sync sample itself is CP sample 0, hence cnt restarts at 1
        state_d = legal ? CP : IDLE;
        cnt_d   = 11'd1;
        sym_d   = 3'd0;
        err_d   = err_q | ~legal;
        ldn_d   = legal ? bus.ldn_rg_i : ldn_q;
        ext_d   = legal ? bus.cp_mode_i : ext_q;
      end else if (state_q == CP) begin
        state_d = cp_end ? BODY : CP;
        cnt_d   = cp_end ? 11'd0 : cnt_q + 11'd1;
      end else if (state_q == BODY) begin
        val_d   = 1'b1;
        bs_d    = cnt_q == 11'd0;
        re_d    = bus.data_real_i;
        im_d    = bus.data_imag_i;
        symo_d  = sym_q;
        state_d = !body_end ? BODY : last ? IDLE : CP;
        cnt_d   = body_end ? 11'd0 : cnt_q + 11'd1;
        sym_d   = body_end && !last ? sym_q + 3'd1 : sym_q;
      end
    end
  end
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sym_q   <= '0;
      ldn_q   <= '0;
      ext_q   <= 1'b0;
      err_q   <= 1'b0;
      val_q   <= 1'b0;
      bs_q    <= 1'b0;
      re_q    <= '0;
      im_q    <= '0;
      symo_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sym_q   <= sym_d;
      ldn_q   <= ldn_d;
      ext_q   <= ext_d;
      err_q   <= err_d;
      val_q   <= val_d;
      bs_q    <= bs_d;
      re_q    <= re_d;
      im_q    <= im_d;
      symo_q  <= symo_d;
    end
  end
  assign bus.block_sync_o = bs_q;
  assign bus.data_val_o   = val_q;
  assign bus.data_real_o  = re_q;
  assign bus.data_imag_o  = im_q;
  assign bus.ldn_rg_o     = ldn_q;
  assign bus.sym_idx_o    = symo_q;
  assign bus.err_o        = err_q;
endmodule
